// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one UART transmit byte path
// among NUM_REQUESTERS byte sources, with revocation of grants that stall too long.
module uart_tx_arbiter #(
    parameter int NUM_REQUESTERS       = 4,
    parameter int STALL_TIMEOUT_CYCLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQUESTERS-1:0]     req_valid,
    input  logic [8*NUM_REQUESTERS-1:0]   req_data,
    input  logic [NUM_REQUESTERS-1:0]     req_last,
    output logic [NUM_REQUESTERS-1:0]     req_ready,
    output logic [NUM_REQUESTERS-1:0]     grant,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    input  logic                          tx_ready,
    output logic                          timeout_pulse
);

    localparam int IDX_W = $clog2(NUM_REQUESTERS);
    localparam int CNT_W = $clog2(STALL_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]          STALL_MAX    = CNT_W'(STALL_TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]          PTR_RESET    = IDX_W'(NUM_REQUESTERS - 1);
    localparam logic [NUM_REQUESTERS-1:0] ONE_HOT_BASE = NUM_REQUESTERS'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t                       state_r;
    logic [NUM_REQUESTERS-1:0]    grant_r;
    logic [IDX_W-1:0]             gidx_r;
    logic [IDX_W-1:0]             ptr_r;
    logic [CNT_W-1:0]             stall_cnt_r;
    logic                         timeout_pulse_r;

    logic [IDX_W-1:0]             pick_s;
    logic                         any_valid_s;
    logic                         gvalid_s;
    logic                         glast_s;
    logic                         xfer_s;
    logic [7:0]                   tx_data_s;

    // First asserted requester searching upward from ptr+1 with wrap; smallest offset wins.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQUESTERS-1:0] valid,
        input logic [IDX_W-1:0]          ptr
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx_l;
        int               idx;
        pick = ptr;
        for (int off = NUM_REQUESTERS; off >= 1; off--) begin
            idx   = (int'(ptr) + off) % NUM_REQUESTERS;
            idx_l = IDX_W'(idx);
            pick  = valid[idx_l] ? idx_l : pick;
        end
        return pick;
    endfunction

    // Selection, granted-requester qualifiers and the transmit data mux
    always_comb begin
        pick_s      = rr_pick(req_valid, ptr_r);
        any_valid_s = |req_valid;
        gvalid_s    = |(req_valid & grant_r);
        glast_s     = |(req_last & grant_r);
        xfer_s      = gvalid_s & tx_ready;
        tx_data_s   = 8'h00;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            tx_data_s = tx_data_s | (req_data[8*i +: 8] & {8{grant_r[i]}});
        end
    end

    // Arbitration FSM: grant, priority pointer, stall counter and timeout pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            grant_r         <= '0;
            gidx_r          <= '0;
            ptr_r           <= PTR_RESET;
            stall_cnt_r     <= '0;
            timeout_pulse_r <= 1'b0;
        end else begin
            timeout_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        state_r     <= ST_GRANTED;
                        grant_r     <= ONE_HOT_BASE << pick_s;
                        gidx_r      <= pick_s;
                        stall_cnt_r <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                    end
                end
                ST_GRANTED: begin
                    if (xfer_s) begin
                        stall_cnt_r <= '0;
                        if (glast_s) begin
                            state_r <= ST_IDLE;
                            grant_r <= '0;
                            ptr_r   <= gidx_r;
                        end else begin
                            state_r <= ST_GRANTED;
                        end
                    end else if (!gvalid_s) begin
                        // Requester went quiet mid-message: count it, revoke once the budget is spent
                        if (stall_cnt_r == STALL_MAX) begin
                            state_r         <= ST_IDLE;
                            grant_r         <= '0;
                            ptr_r           <= gidx_r;
                            stall_cnt_r     <= '0;
                            timeout_pulse_r <= 1'b1;
                        end else begin
                            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        stall_cnt_r <= stall_cnt_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant_r     <= '0;
                    stall_cnt_r <= '0;
                end
            endcase
        end
    end

    assign grant         = grant_r;
    assign req_ready     = grant_r & {NUM_REQUESTERS{tx_ready}};
    assign tx_valid      = gvalid_s;
    assign tx_data       = tx_data_s;
    assign timeout_pulse = timeout_pulse_r;

endmodule
